player_ctrl: RTL and testbench

//  Parametrised successor to the fixed 14-bit player block. Turns pad inputs into a

---
 rtl/player_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_player_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl.sv
// player_ctrl: turns pad inputs into packed player and sword entities on a tile grid, once per frame_tick.
// Optional PLAYER_CTRL_WRAP_EN: moves and sword placement wrap around grid edges instead of clamping.
module player_ctrl #(
    parameter int         X_W           = 4,
    parameter int         Y_W           = 4,
    parameter int         X_MAX         = 15,
    parameter int         Y_MAX         = 11,
    parameter int         SPAWN_X       = 7,
    parameter int         SPAWN_Y       = 5,
    parameter int         HEALTH_W      = 2,
    parameter int         MAX_HEALTH    = 3,
    parameter int         MOVE_FRAMES   = 2,
    parameter int         SWORD_FRAMES  = 4,
    parameter int         INVUL_FRAMES  = 8,
    parameter logic [3:0] PLAYER_SPRITE = 4'h1,
    parameter logic [3:0] DEAD_SPRITE   = 4'h2,
    parameter logic [3:0] SWORD_SPRITE  = 4'h3,
    parameter logic [3:0] NONE_SPRITE   = 4'hF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    up,
    input  logic                    down,
    input  logic                    left,
    input  logic                    right,
    input  logic                    A,
    input  logic                    B,
    input  logic                    select,
    input  logic                    start,
    input  logic                    hit,
    output logic [6+X_W+Y_W-1:0]    player,
    output logic [6+X_W+Y_W-1:0]    sword,
    output logic [HEALTH_W-1:0]     player_health,
    output logic                    player_alive
);

    localparam int E    = 6 + X_W + Y_W;
    localparam int CD_W = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;
    localparam int SW_W = $clog2(SWORD_FRAMES + 1);
    localparam int IV_W = (INVUL_FRAMES > 0) ? $clog2(INVUL_FRAMES + 1) : 1;

    localparam logic [X_W-1:0]      X_LAST       = X_W'(X_MAX);
    localparam logic [Y_W-1:0]      Y_LAST       = Y_W'(Y_MAX);
    localparam logic [X_W-1:0]      SPAWN_XV     = X_W'(SPAWN_X);
    localparam logic [Y_W-1:0]      SPAWN_YV     = Y_W'(SPAWN_Y);
    localparam logic [HEALTH_W-1:0] FULL_HEALTH  = HEALTH_W'(MAX_HEALTH);
    localparam logic [CD_W-1:0]     COOL_RELOAD  = CD_W'(MOVE_FRAMES - 1);
    localparam logic [SW_W-1:0]     SWORD_RELOAD = SW_W'(SWORD_FRAMES);
    localparam logic [IV_W-1:0]     INVUL_RELOAD = IV_W'(INVUL_FRAMES);
    localparam logic [E-1:0]        SWORD_HIDDEN = {2'b00, NONE_SPRITE, {X_W{1'b0}}, {Y_W{1'b0}}};

    localparam logic [1:0] OR_UP    = 2'b00;
    localparam logic [1:0] OR_RIGHT = 2'b01;
    localparam logic [1:0] OR_DOWN  = 2'b10;
    localparam logic [1:0] OR_LEFT  = 2'b11;

`ifdef PLAYER_CTRL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        DEAD
    } state_t;

    state_t              state, state_next;
    logic [1:0]          orient, orient_next;
    logic [3:0]          sprite, sprite_next;
    logic [X_W-1:0]      x, x_next;
    logic [Y_W-1:0]      y, y_next;
    logic [HEALTH_W-1:0] health, health_next;
    logic [CD_W-1:0]     cooldown, cooldown_next;
    logic [IV_W-1:0]     invul, invul_next;
    logic [SW_W-1:0]     timer, timer_next;
    logic                atk_prev, atk_prev_next;
    logic [E-1:0]        sword_reg, sword_next;
    logic                alive, alive_next;

    logic       atk;
    logic       take_hit;
    logic       dir_held;
    logic [1:0] dir;
    logic       ahead_off;
    logic       unused_select;

    assign unused_select = select;

    // One tile step along a direction; at the grid edge it either stays put or wraps.
    function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] cx, input logic [1:0] d);
        logic [X_W-1:0] nx;
        nx = cx;
        if (d == OR_RIGHT) begin
            if (cx == X_LAST) nx = WRAP ? '0 : cx;
            else              nx = cx + X_W'(1);
        end else if (d == OR_LEFT) begin
            if (cx == '0)     nx = WRAP ? X_LAST : cx;
            else              nx = cx - X_W'(1);
        end
        return nx;
    endfunction

    function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] cy, input logic [1:0] d);
        logic [Y_W-1:0] ny;
        ny = cy;
        if (d == OR_DOWN) begin
            if (cy == Y_LAST) ny = WRAP ? '0 : cy;
            else              ny = cy + Y_W'(1);
        end else if (d == OR_UP) begin
            if (cy == '0)     ny = WRAP ? Y_LAST : cy;
            else              ny = cy - Y_W'(1);
        end
        return ny;
    endfunction

    assign atk       = (A | B) & ~atk_prev;
    assign take_hit  = hit && (invul == '0) && (state != DEAD);
    assign dir_held  = up | down | left | right;
    assign dir       = up ? OR_UP : (down ? OR_DOWN : (left ? OR_LEFT : OR_RIGHT));
    assign ahead_off = ((orient == OR_UP)    && (y == '0))     ||
                       ((orient == OR_DOWN)  && (y == Y_LAST)) ||
                       ((orient == OR_LEFT)  && (x == '0))     ||
                       ((orient == OR_RIGHT) && (x == X_LAST));

    always_comb begin
        state_next    = state;
        orient_next   = orient;
        sprite_next   = sprite;
        x_next        = x;
        y_next        = y;
        health_next   = health;
        cooldown_next = cooldown;
        invul_next    = invul;
        timer_next    = timer;
        atk_prev_next = atk_prev;
        sword_next    = sword_reg;
        alive_next    = alive;

        if (frame_tick) begin
            atk_prev_next = A | B;
            if (invul != '0) invul_next = invul - IV_W'(1);

            case (state)
                IDLE: begin
                    if (atk) begin
                        state_next = ATTACK;
                        timer_next = SWORD_RELOAD;
                        sword_next = {orient,
                                      (ahead_off && !WRAP) ? NONE_SPRITE : SWORD_SPRITE,
                                      step_x(x, orient), step_y(y, orient)};
                    end else if (dir_held) begin
                        orient_next = dir;
                        if (cooldown == '0) begin
                            x_next        = step_x(x, dir);
                            y_next        = step_y(y, dir);
                            cooldown_next = COOL_RELOAD;
                        end else begin
                            cooldown_next = cooldown - CD_W'(1);
                        end
                    end else begin
                        cooldown_next = '0;
                    end
                end
                ATTACK: begin
                    // The entry tick already counted as the first sword frame.
                    if (timer <= SW_W'(1)) begin
                        state_next    = IDLE;
                        timer_next    = '0;
                        sword_next    = SWORD_HIDDEN;
                        cooldown_next = '0;
                    end else begin
                        timer_next = timer - SW_W'(1);
                    end
                end
                DEAD: begin
                    if (start) begin
                        state_next    = IDLE;
                        orient_next   = OR_UP;
                        sprite_next   = PLAYER_SPRITE;
                        x_next        = SPAWN_XV;
                        y_next        = SPAWN_YV;
                        health_next   = FULL_HEALTH;
                        cooldown_next = '0;
                        invul_next    = '0;
                        timer_next    = '0;
                        sword_next    = SWORD_HIDDEN;
                        alive_next    = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // Damage is sampled every clock; a fatal hit freezes the player where it stood.
        if (take_hit) begin
            invul_next  = INVUL_RELOAD;
            health_next = (health == '0) ? '0 : health - HEALTH_W'(1);
            if (health <= HEALTH_W'(1)) begin
                health_next   = '0;
                state_next    = DEAD;
                sprite_next   = DEAD_SPRITE;
                orient_next   = orient;
                x_next        = x;
                y_next        = y;
                timer_next    = '0;
                cooldown_next = '0;
                sword_next    = SWORD_HIDDEN;
                alive_next    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            orient   <= OR_UP;
            sprite   <= PLAYER_SPRITE;
            x        <= SPAWN_XV;
            y        <= SPAWN_YV;
            health   <= FULL_HEALTH;
            cooldown <= '0;
            invul    <= '0;
            timer    <= '0;
            atk_prev <= 1'b0;
            sword_reg <= SWORD_HIDDEN;
            alive    <= 1'b1;
        end else begin
            state    <= state_next;
            orient   <= orient_next;
            sprite   <= sprite_next;
            x        <= x_next;
            y        <= y_next;
            health   <= health_next;
            cooldown <= cooldown_next;
            invul    <= invul_next;
            timer    <= timer_next;
            atk_prev <= atk_prev_next;
            sword_reg <= sword_next;
            alive    <= alive_next;
        end
    end

    assign player        = {orient, sprite, x, y};
    assign sword         = sword_reg;
    assign player_health = health;
    assign player_alive  = alive;

endmodule

// File: tb/tb_player_ctrl.sv
// Randomised scoreboard bench for player_ctrl: a tile-level game model predicts every cycle's outputs.
// Honours PLAYER_CTRL_WRAP_EN the same way the design does.
module tb_player_ctrl;

    localparam int X_MAX        = 15;
    localparam int Y_MAX        = 11;
    localparam int SPAWN_X      = 7;
    localparam int SPAWN_Y      = 5;
    localparam int MAX_HEALTH   = 3;
    localparam int MOVE_FRAMES  = 2;
    localparam int SWORD_FRAMES = 4;
    localparam int INVUL_FRAMES = 8;

`ifdef PLAYER_CTRL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0, frame_tick = 1'b0;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic        A = 1'b0, B = 1'b0, select = 1'b0, start = 1'b0, hit = 1'b0;
    logic [13:0] player, sword;
    logic [1:0]  player_health;
    logic        player_alive;

    player_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .up(up), .down(down), .left(left), .right(right),
        .A(A), .B(B), .select(select), .start(start), .hit(hit),
        .player(player), .sword(sword),
        .player_health(player_health), .player_alive(player_alive)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit reset, tick, up, down, left, right, a, b, sel, start, hit;
    } stim_t;

    typedef struct {
        logic [13:0] player;
        logic [13:0] sword;
        logic [1:0]  health;
        logic        alive;
        int          id;
    } expect_t;

    expect_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int issued = 0;

    // Game model: position, facing, hit points and frame counters as plain integers.
    int mx, my, mo, mhp, mcool, minv, mswl;
    bit mdead, mprev, sshow;
    int sx, sy, so, sspr;

    function automatic int fitAxis(input int v, input int maxv);
        if (v < 0)    return WRAP ? maxv : 0;
        if (v > maxv) return WRAP ? 0 : maxv;
        return v;
    endfunction

    task automatic modelReset();
        mx = SPAWN_X; my = SPAWN_Y; mo = 0; mhp = MAX_HEALTH;
        mcool = 0; minv = 0; mswl = 0; mdead = 0; mprev = 0; sshow = 0;
    endtask

    task automatic modelStep(input stim_t s);
        int ox, oy, oo, dx, dy, tx, ty, d;
        bit hurt, press, off;
        if (s.reset) begin
            modelReset();
            return;
        end
        ox = mx; oy = my; oo = mo;
        hurt = s.hit && (minv == 0) && !mdead;
        if (s.tick) begin
            press = (s.a || s.b) && !mprev;
            mprev = s.a || s.b;
            if (minv > 0) minv--;
            if (mdead) begin
                if (s.start) begin
                    modelReset();
                    mprev = s.a || s.b;
                end
            end else if (mswl > 0) begin
                mswl--;
                if (mswl == 0) begin
                    sshow = 0;
                    mcool = 0;
                end
            end else if (press) begin
                mswl = SWORD_FRAMES;
                dx = (mo == 1) ? 1 : ((mo == 3) ? -1 : 0);
                dy = (mo == 2) ? 1 : ((mo == 0) ? -1 : 0);
                tx = mx + dx;
                ty = my + dy;
                off = (tx < 0) || (tx > X_MAX) || (ty < 0) || (ty > Y_MAX);
                sx = fitAxis(tx, X_MAX);
                sy = fitAxis(ty, Y_MAX);
                sspr = (off && !WRAP) ? 15 : 3;
                so = mo;
                sshow = 1;
            end else if (s.up || s.down || s.left || s.right) begin
                d = s.up ? 0 : (s.down ? 2 : (s.left ? 3 : 1));
                mo = d;
                if (mcool == 0) begin
                    mx = fitAxis(mx + ((d == 1) ? 1 : ((d == 3) ? -1 : 0)), X_MAX);
                    my = fitAxis(my + ((d == 2) ? 1 : ((d == 0) ? -1 : 0)), Y_MAX);
                    mcool = MOVE_FRAMES - 1;
                end else begin
                    mcool--;
                end
            end else begin
                mcool = 0;
            end
        end
        if (hurt) begin
            minv = INVUL_FRAMES;
            if (mhp > 0) mhp--;
            if (mhp == 0) begin
                mdead = 1;
                mx = ox; my = oy; mo = oo;
                mswl = 0;
                sshow = 0;
            end
        end
    endtask

    // Drive one clock's worth of inputs and queue what the outputs must show after that edge.
    task automatic applyStimulus(input stim_t s);
        expect_t e;
        @(negedge clk);
        reset = s.reset; frame_tick = s.tick;
        up = s.up; down = s.down; left = s.left; right = s.right;
        A = s.a; B = s.b; select = s.sel; start = s.start; hit = s.hit;
        modelStep(s);
        e.player = {2'(mo), mdead ? 4'h2 : 4'h1, 4'(mx), 4'(my)};
        e.sword  = sshow ? {2'(so), 4'(sspr), 4'(sx), 4'(sy)} : {2'b00, 4'hF, 8'h00};
        e.health = 2'(mhp);
        e.alive  = !mdead;
        e.id     = issued;
        issued++;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input expect_t e);
        vectors++;
        if (player !== e.player || sword !== e.sword ||
            player_health !== e.health || player_alive !== e.alive) begin
            miscompares++;
            $display("[TB] FAIL outputs vec %0d: player %h want %h, sword %h want %h, health %0d want %0d, alive %0d want %0d",
                     e.id, player, e.player, sword, e.sword, player_health, e.health, player_alive, e.alive);
        end
    endtask

    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    // One game tick followed by one quiet cycle, buttons held throughout.
    task automatic holdTicks(input bit u, input bit d, input bit l, input bit r,
                             input bit a, input bit h, input bit st, input int n);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s = '{default: 0};
            s.up = u; s.down = d; s.left = l; s.right = r; s.a = a;
            s.tick = 1; s.hit = h; s.start = st;
            applyStimulus(s);
            s.tick = 0; s.hit = 0; s.start = 0;
            applyStimulus(s);
        end
    endtask

    initial begin
        stim_t s;
        stim_t r;
        s = '{default: 0};
        s.reset = 1;
        applyStimulus(s);
        applyStimulus(s);
        s.reset = 0;
        applyStimulus(s);

        holdTicks(0, 0, 0, 1, 0, 0, 0, 3);
        holdTicks(0, 0, 0, 0, 0, 0, 0, 1);
        holdTicks(1, 0, 0, 0, 0, 0, 0, 1);
        holdTicks(0, 0, 0, 1, 0, 0, 0, 1);
        holdTicks(1, 0, 0, 0, 1, 0, 0, 6);
        holdTicks(1, 0, 0, 0, 0, 0, 0, 2);

        holdTicks(0, 0, 0, 1, 0, 0, 0, 20);
        holdTicks(0, 0, 0, 0, 1, 0, 0, 1);
        holdTicks(0, 0, 0, 0, 0, 0, 0, 5);
        holdTicks(1, 0, 0, 0, 0, 0, 0, 14);
        holdTicks(0, 0, 0, 0, 1, 0, 0, 1);
        holdTicks(0, 0, 0, 0, 0, 0, 0, 5);
        holdTicks(0, 1, 0, 0, 0, 0, 0, 30);
        holdTicks(0, 0, 1, 0, 0, 0, 0, 34);

        for (int t = 0; t <= 20; t++)
            holdTicks(0, 0, 0, 0, 0, (t == 0 || t == 2 || t == 10 || t == 20), 0, 1);
        holdTicks(0, 0, 0, 1, 0, 0, 0, 2);
        holdTicks(0, 0, 0, 1, 0, 0, 1, 1);
        holdTicks(0, 0, 0, 0, 0, 0, 0, 1);

        holdTicks(0, 0, 0, 0, 1, 0, 0, 1);
        s = '{default: 0};
        s.a = 1; s.tick = 1; s.reset = 1;
        applyStimulus(s);
        s = '{default: 0};
        applyStimulus(s);
        applyStimulus(s);

        r = '{default: 0};
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r.up = $urandom_range(0, 3) == 0; r.down = $urandom_range(0, 3) == 0;
                r.left = $urandom_range(0, 3) == 0; r.right = $urandom_range(0, 3) == 0;
            end
            if ($urandom_range(0, 5) == 0) r.a = ~r.a;
            if ($urandom_range(0, 9) == 0) r.b = ~r.b;
            r.tick  = $urandom_range(0, 2) == 0;
            r.hit   = $urandom_range(0, 24) == 0;
            r.start = $urandom_range(0, 3) == 0;
            r.sel   = $urandom_range(0, 1) == 1;
            r.reset = $urandom_range(0, 399) == 0;
            applyStimulus(r);
        end

        repeat (3) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
